// File: rtl/sr_ff_pkg.sv
// Shared types and next-state rule for the bistable cell bank.
// Holds mode enum, SR conflict policy codes and next_q().
package sr_ff_pkg;

  typedef enum logic [1:0] {
    MODE_SR = 2'b00,
    MODE_JK = 2'b01,
    MODE_D  = 2'b10,
    MODE_T  = 2'b11
  } mode_e;

  localparam logic [1:0] POL_HOLD = 2'd0;
  localparam logic [1:0] POL_SET  = 2'd1;
  localparam logic [1:0] POL_RST  = 2'd2;

  function automatic logic next_q(
    input mode_e      m,
    input logic [1:0] pol,
    input logic       q,
    input logic       s,
    input logic       r
  );
    logic n;
    n = q;
    unique case (m)
      MODE_SR: begin
        unique case ({s, r})
          2'b00: n = q;
          2'b01: n = 1'b0;
          2'b10: n = 1'b1;
          default: begin
            unique case (1'b1)
              (pol == POL_SET): n = 1'b1;
              (pol == POL_RST): n = 1'b0;
              default:          n = q;
            endcase
          end
        endcase
      end
      MODE_JK: begin
        unique case ({s, r})
          2'b00:   n = q;
          2'b01:   n = 1'b0;
          2'b10:   n = 1'b1;
          default: n = ~q;
        endcase
      end
      MODE_D:  n = s;
      default: n = q ^ s;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/sr_ff_cell.sv
// One clocked bistable cell: q register plus SR conflict event.
// Ports: clk, rst (sync, low), mode, en, s, r -> q, ev.
module sr_ff_cell
  import sr_ff_pkg::*;
#(
  parameter int POLICY = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mode,
  input  logic       en,
  input  logic       s,
  input  logic       r,
  output logic       q,
  output logic       ev
);

  localparam logic [1:0] PolL = 2'(POLICY);

  logic q_q, q_d;
  mode_e m;

  assign m  = mode_e'(mode);
  assign ev = en && (m == MODE_SR) && s && r;

  always_comb begin
    q_d = q_q;
    if (en) q_d = next_q(m, PolL, q_q, s, r);
  end

  always_ff @(posedge clk) begin
    if (!rst) q_q <= 1'b0;
    else      q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/sr_ff_bank.sv
// Bank of CH SR/JK/D/T cells with sticky conflict flags and
// saturating conflict-cycle counter. Ports: clk, rst, mode, en,
// s, r, conflict_clr -> q, qbar, conflict, conflict_cnt.
module sr_ff_bank
  import sr_ff_pkg::*;
#(
  parameter int CH     = 8,
  parameter int POLICY = 0,
  parameter int CW     = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    mode,
  input  logic [CH-1:0] en,
  input  logic [CH-1:0] s,
  input  logic [CH-1:0] r,
  input  logic          conflict_clr,
  output logic [CH-1:0] q,
  output logic [CH-1:0] qbar,
  output logic [CH-1:0] conflict,
  output logic [CW-1:0] conflict_cnt
);

  localparam logic [CW-1:0] CntMax = '1;

  logic [CH-1:0] ev;
  logic [CH-1:0] conflict_q, conflict_d;
  logic [CW-1:0] cnt_q, cnt_d;

  for (genvar i = 0; i < CH; i++) begin : g_cell
    sr_ff_cell #(.POLICY(POLICY)) u_cell (
      .clk  (clk),
      .rst  (rst),
      .mode (mode),
      .en   (en[i]),
      .s    (s[i]),
      .r    (r[i]),
      .q    (q[i]),
      .ev   (ev[i])
    );
  end

  // A clear and a new event at the same edge: the event survives.
  always_comb begin
    conflict_d = (conflict_clr ? '0 : conflict_q) | ev;
    cnt_d      = conflict_clr ? '0 : cnt_q;
    if ((|ev) && (cnt_d != CntMax)) cnt_d = cnt_d + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      conflict_q <= '0;
      cnt_q      <= '0;
    end else begin
      conflict_q <= conflict_d;
      cnt_q      <= cnt_d;
    end
  end

  assign qbar         = ~q;
  assign conflict     = conflict_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_sr_ff_bank.sv
// Testbench for sr_ff_bank: three instances (policies 0/1/2,
// last with a 2-bit counter) against a behavioural model.
module tb_sr_ff_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] mode;
  logic [7:0] en, s, r;
  logic       conflict_clr;

  logic [7:0] q0, q1, q2, qb0, qb1, qb2, c0, c1, c2;
  logic [7:0] n0, n1;
  logic [1:0] n2;

  int errors = 0;
  int checks = 0;

  logic [7:0] mq[3];
  logic [7:0] mc[3];
  int         mcnt[3];
  int         pol[3]   = '{0, 1, 2};
  int         cmax[3]  = '{255, 255, 3};

  always #5 clk = ~clk;

  sr_ff_bank #(.CH(8), .POLICY(0), .CW(8)) dut0 (
    .clk(clk), .rst(rst), .mode(mode), .en(en), .s(s), .r(r),
    .conflict_clr(conflict_clr), .q(q0), .qbar(qb0),
    .conflict(c0), .conflict_cnt(n0));

  sr_ff_bank #(.CH(8), .POLICY(1), .CW(8)) dut1 (
    .clk(clk), .rst(rst), .mode(mode), .en(en), .s(s), .r(r),
    .conflict_clr(conflict_clr), .q(q1), .qbar(qb1),
    .conflict(c1), .conflict_cnt(n1));

  sr_ff_bank #(.CH(8), .POLICY(2), .CW(2)) dut2 (
    .clk(clk), .rst(rst), .mode(mode), .en(en), .s(s), .r(r),
    .conflict_clr(conflict_clr), .q(q2), .qbar(qb2),
    .conflict(c2), .conflict_cnt(n2));

  // Advance one rising edge; model updated from current inputs.
  task automatic tick();
    logic [7:0] nq, evs;
    int nc;
    for (int k = 0; k < 3; k++) begin
      if (!rst) begin
        mq[k] = 8'h00; mc[k] = 8'h00; mcnt[k] = 0;
      end else begin
        nq  = mq[k];
        evs = 8'h00;
        for (int i = 0; i < 8; i++) begin
          if (en[i]) begin
            case (mode)
              2'd0: begin
                if (s[i] && r[i]) begin
                  evs[i] = 1'b1;
                  if (pol[k] == 1) nq[i] = 1'b1;
                  else if (pol[k] == 2) nq[i] = 1'b0;
                end else if (s[i]) nq[i] = 1'b1;
                else if (r[i]) nq[i] = 1'b0;
              end
              2'd1: begin
                if (s[i] && r[i]) nq[i] = !mq[k][i];
                else if (s[i]) nq[i] = 1'b1;
                else if (r[i]) nq[i] = 1'b0;
              end
              2'd2: nq[i] = s[i];
              default: if (s[i]) nq[i] = !mq[k][i];
            endcase
          end
        end
        mq[k] = nq;
        mc[k] = (conflict_clr ? 8'h00 : mc[k]) | evs;
        nc = conflict_clr ? 0 : mcnt[k];
        if (evs != 0) nc = (nc + 1 > cmax[k]) ? cmax[k] : nc + 1;
        mcnt[k] = nc;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [1:0] m, input logic [7:0] e,
                       input logic [7:0] sv, input logic [7:0] rv,
                       input logic clr);
    mode = m; en = e; s = sv; r = rv; conflict_clr = clr;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(2'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
      tick();
    end
    rst = 1'b1;
    checks++;
    if (q0 !== 8'h00 || q2 !== 8'h00) begin
      errors++; $display("FAIL reset_q q0=%h q2=%h exp=00", q0, q2);
    end
    checks++;
    if (qb0 !== 8'hFF) begin
      errors++; $display("FAIL reset_qbar got=%h exp=ff", qb0);
    end
    checks++;
    if (c0 !== 8'h00 || n0 !== 8'd0 || n2 !== 2'd0) begin
      errors++;
      $display("FAIL reset_conf c=%h n0=%0d n2=%0d exp=0", c0, n0, n2);
    end
  endtask

  task automatic test_sr();
    drive(2'd2, 8'hFF, 8'hF0, 8'h00, 1'b0); tick();
    drive(2'd0, 8'hFF, 8'h0F, 8'hF0, 1'b0); tick();
    checks++;
    if (q0 !== 8'h0F) begin
      errors++; $display("FAIL sr_setrst got=%h exp=0f", q0);
    end
    drive(2'd0, 8'hFF, 8'h01, 8'h01, 1'b0); tick();
    checks++;
    if (q0 !== 8'h0F || c0 !== 8'h01 || n0 !== 8'd1) begin
      errors++;
      $display("FAIL sr_hold q=%h c=%h n=%0d exp=0f 01 1", q0, c0, n0);
    end
    checks++;
    if (q1[0] !== 1'b1 || q2[0] !== 1'b0) begin
      errors++;
      $display("FAIL sr_policy q1=%h q2=%h exp=0f 0e", q1, q2);
    end
  endtask

  task automatic test_jk();
    logic [7:0] exp;
    drive(2'd2, 8'hFF, 8'h00, 8'h00, 1'b1); tick();
    exp = 8'h00;
    for (int i = 0; i < 3; i++) begin
      drive(2'd1, 8'hFF, 8'hFF, 8'hFF, 1'b0); tick();
      exp = ~exp;
      checks++;
      if (q0 !== exp || c0 !== 8'h00 || n0 !== 8'd0) begin
        errors++;
        $display("FAIL jk_toggle%0d q=%h c=%h n=%0d exp=%h 00 0",
                 i, q0, c0, n0, exp);
      end
    end
  endtask

  task automatic test_d_t();
    drive(2'd2, 8'hFF, 8'hA5, 8'h00, 1'b0); tick();
    checks++;
    if (q0 !== 8'hA5) begin
      errors++; $display("FAIL d_load got=%h exp=a5", q0);
    end
    drive(2'd3, 8'hFF, 8'h0F, 8'h00, 1'b0); tick();
    checks++;
    if (q0 !== 8'hAA) begin
      errors++; $display("FAIL t_toggle got=%h exp=aa", q0);
    end
    drive(2'd3, 8'h01, 8'hFF, 8'hFF, 1'b0); tick();
    checks++;
    if (q0 !== 8'hAB) begin
      errors++; $display("FAIL t_enable got=%h exp=ab", q0);
    end
  endtask

  task automatic test_saturate();
    logic [1:0] exp2[5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    for (int i = 0; i < 5; i++) begin
      drive(2'd0, 8'hFF, 8'hFF, 8'hFF, 1'b0); tick();
      checks++;
      if (n2 !== exp2[i] || n0 !== 8'(i + 1) || c2 !== 8'hFF) begin
        errors++;
        $display("FAIL sat_cnt%0d n2=%0d n0=%0d c2=%h exp=%0d %0d ff",
                 i, n2, n0, c2, exp2[i], i + 1);
      end
    end
    drive(2'd0, 8'h00, 8'hFF, 8'hFF, 1'b1); tick();
    checks++;
    if (n2 !== 2'd0 || n0 !== 8'd0 || c2 !== 8'h00) begin
      errors++;
      $display("FAIL clr_only n2=%0d n0=%0d c=%h exp=0 0 00", n2, n0, c2);
    end
    drive(2'd0, 8'h08, 8'h08, 8'h08, 1'b1); tick();
    checks++;
    if (c0 !== 8'h08 || n0 !== 8'd1 || n2 !== 2'd1) begin
      errors++;
      $display("FAIL clr_event c=%h n0=%0d n2=%0d exp=08 1 1", c0, n0, n2);
    end
  endtask

  task automatic test_reset_mid();
    drive(2'd3, 8'hFF, 8'hFF, 8'h00, 1'b0); tick();
    rst = 1'b0; tick();
    checks++;
    if (q0 !== 8'h00 || c0 !== 8'h00) begin
      errors++; $display("FAIL mid_reset q=%h c=%h exp=00 00", q0, c0);
    end
    rst = 1'b1; tick();
    checks++;
    if (q0 !== 8'hFF) begin
      errors++; $display("FAIL post_reset got=%h exp=ff", q0);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      rst = ($urandom_range(0, 29) != 0);
      drive(2'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
            1'($urandom_range(0, 9) == 0));
      tick();
      checks++;
      if (q0 !== mq[0] || q1 !== mq[1] || q2 !== mq[2] ||
          qb0 !== ~mq[0] || qb2 !== ~mq[2]) begin
        errors++;
        $display("FAIL rnd_q%0d got=%h %h %h exp=%h %h %h",
                 n, q0, q1, q2, mq[0], mq[1], mq[2]);
      end
      checks++;
      if (c0 !== mc[0] || c1 !== mc[1] || c2 !== mc[2] ||
          n0 !== 8'(mcnt[0]) || n1 !== 8'(mcnt[1]) ||
          n2 !== 2'(mcnt[2])) begin
        errors++;
        $display("FAIL rnd_conf%0d c=%h n=%0d %0d exp=%h n=%0d %0d",
                 n, c0, n0, n2, mc[0], mcnt[0], mcnt[2]);
      end
    end
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    drive(2'd0, 8'h00, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    test_reset();
    test_sr();
    test_jk();
    test_d_t();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
